// File: rtl/chunked_seq_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands summed CHUNK bits per clock through one ripple slice.
// Latency: out_valid rises NCHUNK edges after the accepting edge; new operands accepted only in IDLE.
// Backpressure: result held in DONE until out_ready; optional saturation on overflow via SEQ_ADDER_SAT_EN.
module chunked_seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_q, b_q;     // b_q holds the already-inverted operand for subtract
  logic              carry_q;
  logic [IDXW-1:0]   idx;
  logic [CHUNK-1:0]  a_c, b_c;
  logic [CHUNK:0]    sum_c;
  logic              last;
  logic              ovf_c;
`ifdef SEQ_ADDER_SAT_EN
  logic [WIDTH-1:0]  sat_val;
`endif

  // Select the current chunk of both operands and ripple-add it with the running carry
  always_comb begin
    a_c = '0;
    b_c = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IDXW'(i)) begin
        a_c = a_q[i*CHUNK +: CHUNK];
        b_c = b_q[i*CHUNK +: CHUNK];
      end
    end
    sum_c = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry_q};
    last  = (idx == IDXW'(NCHUNK - 1));
    // On the last chunk sum_c[CHUNK-1] is the result MSB
    ovf_c = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_c[CHUNK-1] != a_q[WIDTH-1]);
`ifdef SEQ_ADDER_SAT_EN
    sat_val = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  // FSM state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then one chunk per RUN edge
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      S       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_q     <= A;
      b_q     <= sub ? ~B : B;
      carry_q <= sub ? 1'b1 : cin;
      idx     <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < NCHUNK; i++) begin
        if (idx == IDXW'(i)) S[i*CHUNK +: CHUNK] <= sum_c[CHUNK-1:0];
      end
      carry_q <= sum_c[CHUNK];
      idx     <= last ? '0 : idx + IDXW'(1);
      if (last) begin
        cout <= sum_c[CHUNK];
        ovf  <= ovf_c;
`ifdef SEQ_ADDER_SAT_EN
        if (ovf_c) S <= sat_val;
`endif
      end
    end
  end

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Bench for chunked_seq_adder: 16/4 instance driven from a vector table plus
// hand sequences for backpressure and mid-operation reset; a 9/9 instance for the single-chunk case.
module tb_chunked_seq_adder;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;

  logic        in_valid = 1'b0, out_ready = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        in_ready, out_valid, cout, ovf, busy;
  logic [15:0] S;

  logic        iv9 = 1'b0, or9 = 1'b0, sub9 = 1'b0, cin9 = 1'b0;
  logic [8:0]  a9 = '0, b9 = '0;
  logic        ir9, ov9, cout9, ovf9, busy9;
  logic [8:0]  s9;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .cout(cout), .ovf(ovf), .busy(busy)
  );

  chunked_seq_adder #(.WIDTH(9), .CHUNK(9)) dut9 (
    .Clk(Clk), .Reset_n(Reset_n), .in_valid(iv9), .in_ready(ir9),
    .A(a9), .B(b9), .sub(sub9), .cin(cin9), .out_valid(ov9), .out_ready(or9),
    .S(s9), .cout(cout9), .ovf(ovf9), .busy(busy9)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic [15:0] s_sat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    logic [15:0] exp_s;
`ifdef SEQ_ADDER_SAT_EN
    exp_s = v.s_sat;
`else
    exp_s = v.s;
`endif
    @(posedge Clk); #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    A = v.a; B = v.b; sub = v.sub; cin = v.cin; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0; A = 16'hDEAD; B = 16'hBEEF; sub = ~v.sub; cin = ~v.cin;
    chk({tag, "_busy"}, busy, 1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge Clk); #1;
      if (k == 3) chk({tag, "_early_valid"}, out_valid, 0);
    end
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_S"}, S, exp_s);
    chk({tag, "_cout"}, cout, v.cout);
    chk({tag, "_ovf"}, ovf, v.ovf);
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    chk({tag, "_released"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [15:0] hold_s;
    logic        hold_c, hold_o;
    logic [8:0]  exp9;

    vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 16'h0100};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vecs[2]  = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 16'h7FFF};
    vecs[3]  = '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0, 16'h5556};
    vecs[4]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h8000};
    vecs[5]  = '{16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vecs[6]  = '{16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 16'hFFFE};
    vecs[7]  = '{16'h7000, 16'h1000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 16'h7FFF};
    vecs[8]  = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 16'h8000};
    vecs[9]  = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 16'h1000};
    vecs[10] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 16'h000F};

    // Reset state
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_S", S, 16'h0000);
    chk("rst_cout_ovf", {cout, ovf}, 2'b00);
    chk("rst9_ready_valid", {ir9, ov9}, 2'b10);
    @(posedge Clk); #1;
    Reset_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 11; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held while in_valid and operands toggle
    @(posedge Clk); #1;
    A = 16'h00FF; B = 16'h0001; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    chk("bp_valid", out_valid, 1);
    hold_s = S; hold_c = cout; hold_o = ovf;
    chk("bp_S_initial", hold_s, 16'h0100);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; A = 16'h1111 * k[15:0]; B = ~A; sub = k[0];
      @(posedge Clk); #1;
      chk($sformatf("bp_hold_S_%0d", k), S, 16'h0100);
      chk($sformatf("bp_hold_flags_%0d", k), {cout, ovf, out_valid, in_ready, busy}, 5'b00101);
    end
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    chk("bp_release", {out_valid, in_ready, busy}, 3'b010);
    in_valid = 1'b0;
    @(posedge Clk); #1;
    chk("bp_no_accept", busy, 0);

    // Reset after the second RUN edge
    A = 16'h1111; B = 16'h2222; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    chk("midrst_S", S, 16'h0000);
    chk("midrst_flags", {out_valid, in_ready, busy, cout, ovf}, 5'b01000);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    run_op('{16'h1234, 16'h0FED, 1'b1, 1'b0, 16'h0247, 1'b1, 1'b0, 16'h0247}, "after_rst");

    // Single-chunk instance: latency 1
    @(posedge Clk); #1;
    a9 = 9'h1FF; b9 = 9'h001; sub9 = 1'b0; cin9 = 1'b0; iv9 = 1'b1;
    @(posedge Clk); #1;
    iv9 = 1'b0;
    chk("w9_run_valid", {ov9, busy9}, 2'b01);
    @(posedge Clk); #1;
    chk("w9_valid", ov9, 1);
    chk("w9_S", s9, 9'h000);
    chk("w9_cout_ovf", {cout9, ovf9}, 2'b10);
    or9 = 1'b1;
    @(posedge Clk); #1;
    or9 = 1'b0;
    chk("w9_release", {ov9, ir9}, 2'b01);

    // Single-chunk subtract with overflow
`ifdef SEQ_ADDER_SAT_EN
    exp9 = 9'h100;
`else
    exp9 = 9'h0FF;
`endif
    a9 = 9'h100; b9 = 9'h001; sub9 = 1'b1; iv9 = 1'b1;
    @(posedge Clk); #1;
    iv9 = 1'b0;
    @(posedge Clk); #1;
    chk("w9_sub_valid", ov9, 1);
    chk("w9_sub_S", s9, exp9);
    chk("w9_sub_cout_ovf", {cout9, ovf9}, 2'b11);
    or9 = 1'b1;
    @(posedge Clk); #1;
    or9 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
